// File: rtl/pc_unit.sv
// Program-counter unit with jump/branch select, stall and a hardware return-address stack.
// State updates on the falling clock edge; asynchronous active-high reset.
module pc_unit #(
    parameter int            AW        = 5,
    parameter int            STEP      = 1,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = {AW{1'b1}},
    localparam int           CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic [2:0]    pc_sig,
    input  logic [AW-1:0] dir_j,
    input  logic [AW-1:0] dir_b,
    output logic [AW-1:0] pc,
    output logic [CW-1:0] ras_count,
    output logic          ras_full,
    output logic          ras_empty,
    output logic          ras_ovf,
    output logic          ras_unf
);
    localparam int            IW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [AW-1:0] STEP_C  = AW'(STEP);

    localparam logic [2:0] SIG_SEQ    = 3'b000;
    localparam logic [2:0] SIG_JUMP   = 3'b001;
    localparam logic [2:0] SIG_BRANCH = 3'b010;
    localparam logic [2:0] SIG_CALL   = 3'b011;
    localparam logic [2:0] SIG_RETURN = 3'b100;

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] stack_q [RAS_DEPTH];

    logic [AW-1:0] seq;
    logic [CW-1:0] cnt_m1;
    logic [IW-1:0] push_idx, pop_idx;
    logic          full, empty, push;

    assign seq      = pc_q + STEP_C;
    assign cnt_m1   = cnt_q - CW'(1);
    assign push_idx = cnt_q[IW-1:0];
    assign pop_idx  = cnt_m1[IW-1:0];
    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        if (!stall) begin
            case (pc_sig)
                SIG_JUMP:   pc_d = dir_j;
                SIG_BRANCH: pc_d = dir_b;
                SIG_CALL: begin
                    // The jump is taken even when the return address cannot be saved.
                    pc_d = dir_j;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SIG_RETURN: begin
                    if (empty) begin
                        pc_d  = seq;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[pop_idx];
                        cnt_d = cnt_m1;
                    end
                end
                default:    pc_d = seq;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset: entries are only read below ras_count.
    always_ff @(negedge clk) begin
        if (push) begin
            stack_q[push_idx] <= seq;
        end
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign ras_full  = full;
    assign ras_empty = empty;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

    // Keeps SIG_SEQ referenced; sequential fetch is the default decode arm.
    logic unused_seq_sig;
    assign unused_seq_sig = (pc_sig == SIG_SEQ);
endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: default 5-bit instance plus an AW=8/STEP=4 instance.
module tb_pc_unit;
    logic       clk;
    logic       rst;
    logic       stall;
    logic [2:0] pc_sig;
    logic [4:0] dir_j, dir_b;
    logic [4:0] pc;
    logic [2:0] ras_count;
    logic       ras_full, ras_empty, ras_ovf, ras_unf;

    logic       rst2, stall2;
    logic [2:0] pc_sig2;
    logic [7:0] dir_j2, dir_b2, pc2;
    logic [2:0] ras_count2;
    logic       ras_full2, ras_empty2, ras_ovf2, ras_unf2;

    int n_chk  = 0;
    int n_fail = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sig(pc_sig),
        .dir_j(dir_j), .dir_b(dir_b), .pc(pc), .ras_count(ras_count),
        .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    pc_unit #(.AW(8), .STEP(4), .RAS_DEPTH(4), .RESET_PC(8'hFC)) dut8 (
        .clk(clk), .rst(rst2), .stall(stall2), .pc_sig(pc_sig2),
        .dir_j(dir_j2), .dir_b(dir_b2), .pc(pc2), .ras_count(ras_count2),
        .ras_full(ras_full2), .ras_empty(ras_empty2),
        .ras_ovf(ras_ovf2), .ras_unf(ras_unf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       stall;
        logic [2:0] sig;
        logic [4:0] dj;
        logic [4:0] db;
        logic [4:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [2:0] sig, input logic [4:0] dj,
                       input logic [4:0] db, input logic [4:0] epc, input logic [2:0] ecnt,
                       input logic eovf, input logic eunf);
        vec_t v;
        v.stall = s; v.sig = sig; v.dj = dj; v.db = db;
        v.pc = epc; v.cnt = ecnt; v.ovf = eovf; v.unf = eunf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [4:0] epc, input logic [2:0] ecnt,
                             input logic eovf, input logic eunf);
        chk({tag, " pc"}, 32'(pc), 32'(epc));
        chk({tag, " cnt"}, 32'(ras_count), 32'(ecnt));
        chk({tag, " full"}, 32'(ras_full), 32'(ecnt == 3'd4));
        chk({tag, " empty"}, 32'(ras_empty), 32'(ecnt == 3'd0));
        chk({tag, " ovf"}, 32'(ras_ovf), 32'(eovf));
        chk({tag, " unf"}, 32'(ras_unf), 32'(eunf));
    endtask

    task automatic step(input logic s, input logic [2:0] sig, input logic [4:0] dj, input logic [4:0] db);
        stall = s; pc_sig = sig; dir_j = dj; dir_b = db;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // stall, sig, dj, db -> pc, cnt, ovf, unf
        add(0, 3'b000, 5'h00, 5'h00, 5'h00, 3'd0, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h01, 3'd0, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h02, 3'd0, 0, 0);
        add(0, 3'b011, 5'h10, 5'h00, 5'h10, 3'd1, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h11, 3'd1, 0, 0);
        add(0, 3'b011, 5'h18, 5'h00, 5'h18, 3'd2, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h12, 3'd1, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h03, 3'd0, 0, 0);
        add(0, 3'b001, 5'h12, 5'h00, 5'h12, 3'd0, 0, 0);
        add(0, 3'b010, 5'h00, 5'h07, 5'h07, 3'd0, 0, 0);
        add(0, 3'b110, 5'h1C, 5'h1D, 5'h08, 3'd0, 0, 0);
        add(0, 3'b001, 5'h1E, 5'h00, 5'h1E, 3'd0, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h1F, 3'd0, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h00, 3'd0, 0, 0);
        add(0, 3'b011, 5'h01, 5'h00, 5'h01, 3'd1, 0, 0);
        add(0, 3'b011, 5'h02, 5'h00, 5'h02, 3'd2, 0, 0);
        add(0, 3'b011, 5'h03, 5'h00, 5'h03, 3'd3, 0, 0);
        add(0, 3'b011, 5'h04, 5'h00, 5'h04, 3'd4, 0, 0);
        add(0, 3'b011, 5'h1A, 5'h00, 5'h1A, 3'd4, 1, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h1B, 3'd4, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h04, 3'd3, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h03, 3'd2, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h02, 3'd1, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h01, 3'd0, 0, 0);
        add(0, 3'b001, 5'h05, 5'h00, 5'h05, 3'd0, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h06, 3'd0, 0, 1);
        add(0, 3'b000, 5'h00, 5'h00, 5'h07, 3'd0, 0, 0);
        add(0, 3'b101, 5'h1C, 5'h00, 5'h08, 3'd0, 0, 0);
        add(0, 3'b111, 5'h1C, 5'h00, 5'h09, 3'd0, 0, 0);
        add(0, 3'b011, 5'h09, 5'h00, 5'h09, 3'd1, 0, 0);
        add(1, 3'b001, 5'h15, 5'h00, 5'h09, 3'd1, 0, 0);
        add(1, 3'b001, 5'h15, 5'h00, 5'h09, 3'd1, 0, 0);
        add(1, 3'b001, 5'h15, 5'h00, 5'h09, 3'd1, 0, 0);
        add(0, 3'b001, 5'h15, 5'h00, 5'h15, 3'd1, 0, 0);
        add(1, 3'b100, 5'h00, 5'h00, 5'h15, 3'd1, 0, 0);
        add(0, 3'b100, 5'h00, 5'h00, 5'h0A, 3'd0, 0, 0);
        add(1, 3'b100, 5'h00, 5'h00, 5'h0A, 3'd0, 0, 0);
        add(0, 3'b000, 5'h00, 5'h00, 5'h0B, 3'd0, 0, 0);

        rst = 1'b1; stall = 1'b0; pc_sig = 3'b000; dir_j = '0; dir_b = '0;
        rst2 = 1'b1; stall2 = 1'b0; pc_sig2 = 3'b000; dir_j2 = '0; dir_b2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_state("reset", 5'h1F, 3'd0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].stall, vecs[i].sig, vecs[i].dj, vecs[i].db);
            chk_state($sformatf("v%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end

        // Asynchronous reset between edges while the stack holds two entries.
        step(0, 3'b011, 5'h05, 5'h00);
        step(0, 3'b011, 5'h14, 5'h00);
        chk_state("pre_arst", 5'h14, 3'd2, 0, 0);
        stall = 1'b0; pc_sig = 3'b000;
        #2 rst = 1'b1;
        #1;
        chk_state("arst_now", 5'h1F, 3'd0, 0, 0);
        @(negedge clk);
        #1;
        chk_state("arst_held", 5'h1F, 3'd0, 0, 0);
        rst = 1'b0;
        step(0, 3'b000, 5'h00, 5'h00);
        chk_state("arst_seq", 5'h00, 3'd0, 0, 0);

        // Reset pulse clears a pending overflow pulse.
        step(0, 3'b011, 5'h01, 5'h00);
        step(0, 3'b011, 5'h02, 5'h00);
        step(0, 3'b011, 5'h03, 5'h00);
        step(0, 3'b011, 5'h04, 5'h00);
        step(0, 3'b011, 5'h0F, 5'h00);
        chk_state("ovf2", 5'h0F, 3'd4, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk_state("ovf_rst", 5'h1F, 3'd0, 0, 0);
        rst = 1'b0;

        // Wide instance: AW=8, STEP=4, RESET_PC=FC.
        #1;
        chk("w8 reset pc", 32'(pc2), 32'h0000_00FC);
        chk("w8 reset cnt", 32'(ras_count2), 32'd0);
        rst2 = 1'b0;
        @(negedge clk); #1;
        chk("w8 seq0", 32'(pc2), 32'h0000_0000);
        @(negedge clk); #1;
        chk("w8 seq1", 32'(pc2), 32'h0000_0004);
        pc_sig2 = 3'b011; dir_j2 = 8'h80;
        @(negedge clk); #1;
        chk("w8 call pc", 32'(pc2), 32'h0000_0080);
        chk("w8 call cnt", 32'(ras_count2), 32'd1);
        pc_sig2 = 3'b100;
        @(negedge clk); #1;
        chk("w8 ret pc", 32'(pc2), 32'h0000_0008);
        chk("w8 ret empty", 32'(ras_empty2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
